// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, least significant digit first,
// wrapped in a start/busy/done handshake around a single-digit correcting BCD adder.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One decimal digit step: returns {carry_out, corrected_digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] z;
        logic [4:0] zc;
        logic       corr;
        z    = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        corr = z[4] | (z[3] & z[2]) | (z[3] & z[1]);
        zc   = z + 5'd6;
        return {corr, corr ? zc[3:0] : z[3:0]};
    endfunction

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [W+3:0]     acc;

    logic [4:0]       step;
    logic [W+3:0]     acc_nxt;
    logic             step_bad;

    // Operands shift right so the active digit always sits in [3:0]; results
    // enter acc from the top, leaving digit 0 in acc[7:4] after the last step.
    always_comb begin
        step     = bcd_digit_add(a_sh[3:0], b_sh[3:0], carry);
        acc_nxt  = {step[3:0], acc[W+3:4]};
        step_bad = digit_bad(a_sh[3:0]) | digit_bad(b_sh[3:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= cin;
                        idx     <= '0;
                        acc     <= '0;
                        invalid <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 4;
                    b_sh    <= b_sh >> 4;
                    carry   <= step[4];
                    acc     <= acc_nxt;
                    invalid <= invalid | step_bad;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        sum   <= acc_nxt[W+3:4];
                        cout  <= step[4];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a digit-wise decimal reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int BOUND  = 4 * DIGITS + 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int checks   = 0;
    int failures = 0;

    // Observations collected by do_op for the calling test to judge.
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_inv;
    int           o_busy_cnt;
    logic         o_timeout;
    logic         o_first_busy;
    logic         o_inv_first;
    logic         o_sum_changed;
    logic         o_busy_at_done;
    logic         o_done_after;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal addition digit by digit: a digit sum above 9 is corrected by +6 (mod 16) and carries.
    function automatic void ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rc, output logic [W-1:0] rs,
                                    output logic rco, output logic rinv);
        int c;
        int s;
        int da;
        int db;
        c    = rc ? 1 : 0;
        rs   = '0;
        rinv = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            da = int'(ra[4*i +: 4]);
            db = int'(rb[4*i +: 4]);
            if (da > 9 || db > 9) rinv = 1'b1;
            s = da + db + c;
            if (s > 9) begin
                s = (s + 6) % 16;
                c = 1;
            end else begin
                c = 0;
            end
            rs[4*i +: 4] = 4'(s);
        end
        rco = (c != 0);
    endfunction

    function automatic logic [W-1:0] rand_operand(input bit allow_bad);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0)
                v[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        int           cyc;
        logic [W-1:0] sum_before;
        sum_before = sum;
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        o_first_busy  = busy;
        o_inv_first   = invalid;
        o_sum_changed = 1'b0;
        o_busy_cnt    = 0;
        o_timeout     = 1'b0;
        cyc           = 0;
        while (done !== 1'b1) begin
            if (busy === 1'b1) o_busy_cnt++;
            if (sum !== sum_before) o_sum_changed = 1'b1;
            if (cyc > BOUND) begin
                o_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        o_sum          = sum;
        o_cout         = cout;
        o_inv          = invalid;
        o_busy_at_done = busy;
        @(negedge clk);
        o_done_after = done;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h5678;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, invalid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b invalid=%b required all zero",
                     busy, done, sum, cout, invalid);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [6];
        logic [W-1:0] tbv[6];
        logic         tc [6];
        logic [W-1:0] es [6];
        logic         ec [6];
        logic         ei [6];
        ta = '{16'h1234, 16'h9999, 16'h0000, 16'h0099, 16'h00A0, 16'h0001};
        tbv = '{16'h5678, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001};
        tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        es = '{16'h6912, 16'h0000, 16'h0001, 16'h0100, 16'h0000, 16'h0002};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        // Expected for 0x00A0+0: digit 1 is 10 -> corrected to 0 with carry into digit 2.
        es[4] = 16'h0100;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tbv[i], tc[i]);
            checks++;
            if (o_timeout || o_sum !== es[i] || o_cout !== ec[i] || o_inv !== ei[i]) begin
                failures++;
                $display("FAIL directed_%0d: sum=%h cout=%b inv=%b timeout=%b required sum=%h cout=%b inv=%b",
                         i, o_sum, o_cout, o_inv, o_timeout, es[i], ec[i], ei[i]);
            end
            checks++;
            if (o_busy_cnt != DIGITS || !o_first_busy || o_busy_at_done !== 1'b0 || o_done_after !== 1'b0) begin
                failures++;
                $display("FAIL directed_timing_%0d: busy_cycles=%0d first_busy=%b busy_at_done=%b done_next=%b required %0d 1 0 0",
                         i, o_busy_cnt, o_first_busy, o_busy_at_done, o_done_after, DIGITS);
            end
        end
        // Last op followed an invalid one: invalid must be cleared at acceptance.
        checks++;
        if (o_inv_first !== 1'b0) begin
            failures++;
            $display("FAIL invalid_cleared_on_start: invalid=%b required 0", o_inv_first);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        int           bad = 0;
        for (int n = 0; n < 40; n++) begin
            ra = rand_operand(n % 3 == 0);
            rb = rand_operand(n % 5 == 0);
            rc = 1'($urandom);
            ref_add(ra, rb, rc, es, ec, ei);
            do_op(ra, rb, rc);
            checks++;
            if (o_timeout || o_sum !== es || o_cout !== ec || o_inv !== ei || o_sum_changed
                || o_busy_cnt != DIGITS || o_inv_first !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL random_%0d a=%h b=%h cin=%b: sum=%h cout=%b inv=%b busy_cycles=%0d sum_moved=%b required sum=%h cout=%b inv=%b busy_cycles=%0d",
                         n, ra, rb, rc, o_sum, o_cout, o_inv, o_busy_cnt, o_sum_changed, es, ec, ei, DIGITS);
            end
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        int           cyc;
        int           dones;
        int           busies;
        logic         prev_done;
        logic         gap_bad;
        // Start held through RUN and DONE while operands keep changing.
        ra = 16'h4567;
        rb = 16'h3456;
        ref_add(ra, rb, 1'b1, es, ec, ei);
        a     = ra;
        b     = rb;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        cyc = 0;
        while (done !== 1'b1 && cyc <= BOUND) begin
            a   = rand_operand(1'b1);
            b   = rand_operand(1'b1);
            cin = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1 || sum !== es || cout !== ec || invalid !== ei) begin
            failures++;
            $display("FAIL held_first_operands: done=%b sum=%h cout=%b inv=%b required done=1 sum=%h cout=%b inv=%b",
                     done, sum, cout, invalid, es, ec, ei);
        end
        start  = 1'b0;
        dones  = 0;
        busies = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
        end
        checks++;
        if (dones != 0 || busies != 0) begin
            failures++;
            $display("FAIL start_not_queued: done_pulses=%0d busy_cycles=%0d required 0 0", dones, busies);
        end
        // Start held continuously: each op re-accepted only after an IDLE cycle.
        ra = 16'h0858;
        rb = 16'h0143;
        ref_add(ra, rb, 1'b0, es, ec, ei);
        a         = ra;
        b         = rb;
        cin       = 1'b0;
        start     = 1'b1;
        dones     = 0;
        prev_done = 1'b0;
        gap_bad   = 1'b0;
        repeat (3 * (DIGITS + 2)) begin
            @(negedge clk);
            if (prev_done && busy === 1'b1) gap_bad = 1'b1;
            if (done === 1'b1) dones++;
            prev_done = (done === 1'b1);
        end
        start = 1'b0;
        checks++;
        if (dones != 3 || gap_bad || sum !== es || cout !== ec) begin
            failures++;
            $display("FAIL held_continuous: done_pulses=%0d gap_violation=%b sum=%h cout=%b required 3 0 sum=%h cout=%b",
                     dones, gap_bad, sum, cout, es, ec);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        int           dones;
        int           busies;
        do_op(16'h12A4, 16'h1111, 1'b1);
        a     = 16'h2222;
        b     = 16'h3333;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout, invalid} !== '0) begin
            failures++;
            $display("FAIL reset_midrun_async: busy=%b done=%b sum=%h cout=%b invalid=%b required all zero",
                     busy, done, sum, cout, invalid);
        end
        @(negedge clk);
        rst    = 1'b0;
        dones  = 0;
        busies = 0;
        repeat (2 * DIGITS + 4) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) busies++;
        end
        checks++;
        if (dones != 0 || busies != 0) begin
            failures++;
            $display("FAIL reset_midrun_abort: done_pulses=%0d busy_cycles=%0d required 0 0", dones, busies);
        end
        ref_add(16'h7385, 16'h2619, 1'b1, es, ec, ei);
        do_op(16'h7385, 16'h2619, 1'b1);
        checks++;
        if (o_timeout || o_sum !== es || o_cout !== ec || o_inv !== ei || o_busy_cnt != DIGITS) begin
            failures++;
            $display("FAIL after_reset_op: sum=%h cout=%b inv=%b busy_cycles=%0d required sum=%h cout=%b inv=%b busy_cycles=%0d",
                     o_sum, o_cout, o_inv, o_busy_cnt, es, ec, ei, DIGITS);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] es;
        logic         ec;
        logic         ei;
        for (int n = 0; n < 6; n++) begin
            ra = rand_operand(1'b0);
            rb = rand_operand(1'b0);
            rc = 1'(n & 1);
            ref_add(ra, rb, rc, es, ec, ei);
            do_op(ra, rb, rc);
            checks++;
            if (o_timeout || o_sum !== es || o_cout !== ec || o_inv !== ei || !o_first_busy) begin
                failures++;
                $display("FAIL back_to_back_%0d: sum=%h cout=%b inv=%b first_busy=%b required sum=%h cout=%b inv=%b first_busy=1",
                         n, o_sum, o_cout, o_inv, o_first_busy, es, ec, ei);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
